hram_ctl: RTL and testbench

Parametrised, clocked successor to the fixed 127x8 high-RAM macro. It decodes a window of the FFxx page, sequences each access through explicit precharge, access and hold phases, and registers read data. A reset-time clear sequencer zeroes the array. It sits on the SoC internal bus beside the other FFxx register blocks.

---
 rtl/hram_ctl.sv | 103 ++++++++++
 tb/tb_hram_ctl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hram_ctl.sv
// Clocked high-RAM block for a window of the FFxx page. Each access goes through
// precharge (IDLE), ACCESS and HOLD. A clear sequencer zeroes the array after reset.
module hram_ctl #(
  parameter int          DATA_W         = 8,
  parameter int          DEPTH          = 127,
  parameter logic [7:0]  BASE           = 8'h80,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ffxx,
  input  logic [7:0]        a,
  input  logic              soc_rd,
  input  logic              soc_wr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic              hit,
  output logic              busy
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] WIN_LO = {1'b0, BASE};
  localparam logic [8:0] WIN_HI = {1'b0, BASE} + 9'(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, HOLD} state_t;

  state_t                state;
  logic [IDX_W-1:0]      clr_cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_p0;
  logic [7:0]            addr_p0;
  logic                  op_wr_p0;
  logic                  req_held;
  logic [DATA_W-1:0]     mem [DEPTH];

  // 9-bit compare so a window ending exactly at FFFF (BASE+DEPTH = 256) is legal
  assign hit      = ffxx && ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  assign idx      = IDX_W'(a - BASE);
  assign req_held = (op_wr_p0 ? soc_wr : soc_rd) && (a == addr_p0);

  // Array write port. Enables come only from registered state, so an async
  // reset in the middle of an access either commits a whole word or nothing.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_cnt] <= '0;
    else if (state == ACCESS && op_wr_p0)
      mem[idx_p0] <= d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      busy     <= CLEAR_ON_RESET;
      clr_cnt  <= '0;
      d_out    <= '0;
      d_oe     <= 1'b0;
      idx_p0   <= '0;
      addr_p0  <= '0;
      op_wr_p0 <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          d_oe <= 1'b0;
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          d_oe <= 1'b0;
          if (hit && (soc_rd || soc_wr)) begin
            state    <= ACCESS;
            idx_p0   <= idx;
            addr_p0  <= a;
            op_wr_p0 <= soc_wr;
          end
        end
        ACCESS: begin
          if (!op_wr_p0) begin
            d_out <= mem[idx_p0];
            d_oe  <= 1'b1;
          end
          state <= HOLD;
        end
        HOLD: begin
          // A new address or a dropped request goes back through one precharge cycle
          if (!req_held) begin
            state <= IDLE;
            d_oe  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          d_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hram_ctl.sv
// Directed bench for hram_ctl: decode table, read/write sequences, held requests and reset aborts.
module tb_hram_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ffxx;
  logic [7:0] a;
  logic       soc_rd;
  logic       soc_wr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       hit;
  logic       busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       ff;
    logic [7:0] addr;
    logic       exp_hit;
  } hit_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } rd_vec_t;

  hit_vec_t hv[7];
  rd_vec_t  rv[5];

  hram_ctl #(.DATA_W(8), .DEPTH(127), .BASE(8'h80), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .ffxx(ffxx), .a(a), .soc_rd(soc_rd), .soc_wr(soc_wr),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .hit(hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    ffxx = 1'b1; a = addr; d_in = data; soc_wr = 1'b1;
    tick();
    tick();
    check("wr_doe_low", {31'd0, d_oe}, 32'd0);
    soc_wr = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
    ffxx = 1'b1; a = addr; soc_rd = 1'b1;
    tick();
    check({name, "_doe_first_edge"}, {31'd0, d_oe}, 32'd0);
    tick();
    check({name, "_doe"}, {31'd0, d_oe}, 32'd1);
    check({name, "_data"}, {24'd0, d_out}, {24'd0, exp});
    tick();
    check({name, "_hold"}, {23'd0, d_oe, d_out}, {23'd0, 1'b1, exp});
    soc_rd = 1'b0;
    tick();
    check({name, "_doe_drop"}, {31'd0, d_oe}, 32'd0);
  endtask

  task automatic wait_clear(input string name);
    int cnt = 0;
    do begin
      tick();
      cnt++;
      if (d_oe !== 1'b0) check({name, "_doe_in_clear"}, {31'd0, d_oe}, 32'd0);
    end while (busy === 1'b1 && cnt < 300);
    check({name, "_busy_cycles"}, cnt, 127);
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 127; i++)
      do_read(8'h80 + 8'(i), 8'h00, name);
  endtask

  initial begin
    reset = 1'b1; ffxx = 1'b0; a = 8'h00; soc_rd = 1'b0; soc_wr = 1'b0; d_in = 8'h00;

    hv[0] = '{1'b1, 8'h80, 1'b1};
    hv[1] = '{1'b1, 8'hFE, 1'b1};
    hv[2] = '{1'b1, 8'hFF, 1'b0};
    hv[3] = '{1'b1, 8'h7F, 1'b0};
    hv[4] = '{1'b0, 8'h90, 1'b0};
    hv[5] = '{1'b1, 8'hBF, 1'b1};
    hv[6] = '{1'b1, 8'h00, 1'b0};

    // Reset state and clear length
    #3;
    check("rst_dout", {24'd0, d_out}, 32'd0);
    check("rst_doe", {31'd0, d_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_clear("clr0");

    // Cleared words read back as zero
    rv[0] = '{8'h80, 8'h00};
    rv[1] = '{8'hBF, 8'h00};
    rv[2] = '{8'hFE, 8'h00};
    for (int i = 0; i < 3; i++) do_read(rv[i].addr, rv[i].data, "rd_clear");

    // Window decode
    for (int i = 0; i < 7; i++) begin
      ffxx = hv[i].ff; a = hv[i].addr;
      #1;
      check("hit_decode", {31'd0, hit}, {31'd0, hv[i].exp_hit});
    end

    do_write(8'h80, 8'h5A);
    do_write(8'hFE, 8'hC3);
    do_read(8'h80, 8'h5A, "rd_80");
    do_read(8'hFE, 8'hC3, "rd_fe");

    // Out-of-window accesses are ignored
    ffxx = 1'b1; a = 8'hFF; soc_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("oow_ffff_doe", {31'd0, d_oe}, 32'd0); end
    soc_rd = 1'b0; a = 8'h7F; d_in = 8'hEE; soc_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("oow_ff7f_doe", {31'd0, d_oe}, 32'd0); end
    ffxx = 1'b0; a = 8'h90; soc_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("oow_noff_doe", {31'd0, d_oe}, 32'd0); end
    soc_wr = 1'b0; ffxx = 1'b1;
    tick();
    rv[0] = '{8'h80, 8'h5A};
    rv[1] = '{8'hFE, 8'hC3};
    rv[2] = '{8'h90, 8'h00};
    for (int i = 0; i < 3; i++) do_read(rv[i].addr, rv[i].data, "rd_after_oow");

    // Held write executes once with the data present at the access edge
    ffxx = 1'b1; a = 8'h90; d_in = 8'h11; soc_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) d_in = 8'h22;
    end
    soc_wr = 1'b0;
    tick();
    do_read(8'h90, 8'h11, "rd_held_wr");

    // Simultaneous rd and wr: write wins, no drive
    a = 8'hA0; d_in = 8'h77; soc_rd = 1'b1; soc_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); check("rdwr_doe", {31'd0, d_oe}, 32'd0); end
    soc_rd = 1'b0; soc_wr = 1'b0;
    tick();
    do_read(8'hA0, 8'h77, "rd_a0");

    // Reset during HOLD of a read
    a = 8'h80; soc_rd = 1'b1;
    tick();
    tick();
    check("hold_doe_before_rst", {31'd0, d_oe}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_hold_doe", {31'd0, d_oe}, 32'd0);
    check("rst_hold_busy", {31'd0, busy}, 32'd1);
    soc_rd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_clear("clr1");
    read_all_zero("zero1");

    // Reset during CLEAR at clr_cnt = 40; bus writes in CLEAR are dropped
    do_write(8'hFE, 8'hAB);
    do_write(8'h81, 8'hCD);
    do_read(8'h81, 8'hCD, "rd_81");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ffxx = 1'b1; a = 8'hFE; d_in = 8'h55; soc_wr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 10 == 0) check("clr_wr_doe", {31'd0, d_oe}, 32'd0);
    end
    soc_wr = 1'b0;
    check("clr_mid_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_clr_doe", {31'd0, d_oe}, 32'd0);
    check("rst_clr_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_clear("clr2");
    read_all_zero("zero2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
